// File: rtl/nonce_decoder_if.sv
// Per-cycle result slot from the hashing cores: a hit flag and the index of
// the core/partition that produced it.
interface processorResultsIfc #(
   parameter int PARTITIONBITS = 2
) (
   input logic clk
);
   logic [PARTITIONBITS-1:0] nonce_prefix;
   logic                     success;

   modport writer (output nonce_prefix, output success);
   modport reader (input  nonce_prefix, input  success);
endinterface

// File: rtl/nonce_decoder.sv
// Rebuilds the full 32-bit nonce for each core result. The upper bits are the
// reporting core index and the lower bits are the per-core iteration count.
// The first BROADCAST_CNT valid slots after a new block are pipeline fill and
// are dropped.
module nonce_decoder #(
   parameter int BROADCAST_CNT = 5,
   parameter int NUM_CORES     = 4,   // must be a power of two
   parameter int PARTITIONBITS = $clog2(NUM_CORES)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      valid_i,
   input  logic                      newblock_i,
   processorResultsIfc.reader        rawinput_i,
   output logic                      valid_o,
   output logic                      success_o,
   output logic [31:0]               nonce_o
);
   localparam int ITERW = 32 - PARTITIONBITS;
   localparam int FILLW = $clog2(BROADCAST_CNT + 1);
   localparam logic [FILLW-1:0] FILL_MAX = FILLW'(BROADCAST_CNT);

   logic [ITERW-1:0] iter_q;
   logic [FILLW-1:0] fill_q;
   logic             filled;
   logic             decode;

   // Classify the current slot: only a valid, non-newblock slot after the
   // pipeline has filled carries a meaningful result.
   always_comb begin
      filled = (fill_q == FILL_MAX);
      decode = valid_i && !newblock_i && filled;
   end

   // Counters and registered outputs. ITER wraps naturally at its width.
   always_ff @(posedge clk) begin
      if (rst) begin
         iter_q    <= '0;
         fill_q    <= '0;
         valid_o   <= 1'b0;
         success_o <= 1'b0;
         nonce_o   <= '0;
      end else begin
         valid_o   <= decode;
         success_o <= decode && rawinput_i.success;
         if (valid_i) begin
            if (newblock_i) begin
               iter_q <= '0;
               fill_q <= '0;
            end else if (!filled) begin
               fill_q <= fill_q + 1'b1;
            end else begin
               nonce_o <= {rawinput_i.nonce_prefix, iter_q};
               iter_q  <= iter_q + 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_nonce_decoder.sv
// Directed checks of the nonce decoder with BROADCAST_CNT=5, NUM_CORES=4.
module tb_nonce_decoder;
   logic        clk = 1'b0;
   logic        rst, valid_i, newblock_i;
   logic        valid_o, success_o;
   logic [31:0] nonce_o;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   processorResultsIfc #(.PARTITIONBITS(2)) rif (.clk(clk));

   nonce_decoder #(.BROADCAST_CNT(5), .NUM_CORES(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .valid_i    (valid_i),
      .newblock_i (newblock_i),
      .rawinput_i (rif),
      .valid_o    (valid_o),
      .success_o  (success_o),
      .nonce_o    (nonce_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk3(input string tag, input logic v, input logic s, input logic [31:0] n);
      chk({tag, ".valid"}, {31'd0, valid_o}, {31'd0, v});
      chk({tag, ".success"}, {31'd0, success_o}, {31'd0, s});
      chk({tag, ".nonce"}, nonce_o, n);
   endtask

   // Apply one cycle of inputs away from the edge, then sample just after it.
   task automatic step(input logic r, input logic v, input logic nb, input logic s, input logic [1:0] p);
      @(negedge clk);
      rst = r; valid_i = v; newblock_i = nb;
      rif.success = s; rif.nonce_prefix = p;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; valid_i = 1'b0; newblock_i = 1'b0;
      rif.success = 1'b0; rif.nonce_prefix = 2'd0;

      // Reset with idle inputs, then stay idle.
      step(1, 0, 0, 0, 0);
      chk3("reset", 0, 0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 1, 1, 3);
         chk3("idle", 0, 0, 32'h0);
      end

      // New block, 5 fill slots (hits ignored), then 10 decoded slots.
      step(0, 1, 1, 1, 1);
      chk3("nb1", 0, 0, 32'h0);
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 0, 1, 1);
         chk3("fill1", 0, 0, 32'h0);
      end
      for (int i = 0; i < 10; i++) begin
         step(0, 1, 0, 0, 1);
         chk3("dec1", 1, 0, 32'h4000_0000 + i);
      end

      // New block; single hit on the third decoded slot.
      step(0, 1, 1, 0, 1);
      chk3("nb2", 0, 0, 32'h4000_0009);
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 0, 0, 1);
         chk3("fill2", 0, 0, 32'h4000_0009);
      end
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 0, (i == 2), 1);
         chk3("dec2", 1, (i == 2), 32'h4000_0000 + i);
      end

      // Three-cycle valid gap: inputs ignored, outputs hold nonce.
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 1, 1, 3);
         chk3("gap", 0, 0, 32'h4000_0003);
      end
      for (int i = 4; i < 7; i++) begin
         step(0, 1, 0, 0, 3);
         chk3("resume", 1, 0, 32'hC000_0000 + i);
      end

      // Second newblock mid-stream restarts enumeration.
      step(0, 1, 1, 1, 2);
      chk3("nb3", 0, 0, 32'hC000_0006);
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 0, 1, 2);
         chk3("fill3", 0, 0, 32'hC000_0006);
      end
      step(0, 1, 0, 1, 2);
      chk3("restart0", 1, 1, 32'h8000_0000);
      step(0, 1, 0, 0, 2);
      chk3("restart1", 1, 0, 32'h8000_0001);

      // Reset mid-stream dominates valid/success inputs.
      step(1, 1, 0, 1, 2);
      chk3("midrst", 0, 0, 32'h0);
      step(0, 1, 1, 0, 1);
      chk3("nb4", 0, 0, 32'h0);
      for (int i = 0; i < 5; i++) begin
         step(0, 1, 0, 0, 1);
         chk3("fill4", 0, 0, 32'h0);
      end
      step(0, 1, 0, 1, 3);
      chk3("post_rst0", 1, 1, 32'hC000_0000);
      step(0, 0, 0, 0, 0);
      chk3("post_rst_idle", 0, 0, 32'hC000_0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/nonce_decoder.md
NONCE_DECODER -- requirements
Module: nonce_decoder

Interface
REQ-001 Parameter BROADCAST_CNT, default 5, number of valid cycles after a new block before core results become meaningful (pipeline fill depth).
REQ-002 Parameter NUM_CORES, default 4, number of hashing cores; SHALL be a power of two.
REQ-003 Parameter PARTITIONBITS, derived as log2(NUM_CORES) (2 for the default), width of the core/partition prefix.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 valid_i  input  1  core pipeline advanced this cycle; a result slot is present.
REQ-007 newblock_i  input  1  qualified by valid_i; start of a new block, restarts nonce enumeration.
REQ-008 rawinput_i  interface  processorResultsIfc.reader  per-cycle core result: success (1 bit), nonce_prefix (PARTITIONBITS bits, index of reporting core/partition).
REQ-009 valid_o  output  1  registered; a decoded result is presented this cycle.
REQ-010 success_o  output  1  registered; the decoded result is a hit.
REQ-011 nonce_o  output  32  registered; reconstructed full nonce.
REQ-012 processorResultsIfc SHALL take parameter PARTITIONBITS and port clk, declare logic nonce_prefix[PARTITIONBITS-1:0] and success, and provide modports writer (both outputs) and reader (both inputs).

Function
REQ-013 Internal iteration counter ITER, width 32-PARTITIONBITS, holds per-core nonce index of the result currently arriving.
REQ-014 Internal fill counter FILL, 0..BROADCAST_CNT, saturating.
REQ-015 Cycle with valid_i=1 and newblock_i=1: ITER<=0, FILL<=0, valid_o<=0, success_o<=0; nonce_o holds.
REQ-016 Cycle with valid_i=1, newblock_i=0, FILL<BROADCAST_CNT: FILL<=FILL+1, valid_o<=0, success_o<=0, ITER holds (pipeline-fill results discarded).
REQ-017 Cycle with valid_i=1, newblock_i=0, FILL==BROADCAST_CNT: valid_o<=1, success_o<=rawinput_i.success, nonce_o<={rawinput_i.nonce_prefix, ITER}, ITER<=ITER+1.
REQ-018 nonce_o layout: prefix in bits [31:32-PARTITIONBITS], ITER in bits [31-PARTITIONBITS:0].
REQ-019 ITER SHALL wrap modulo 2^(32-PARTITIONBITS) without flagging.
REQ-020 Cycle with valid_i=0: valid_o<=0, success_o<=0, ITER/FILL/nonce_o hold; newblock_i ignored.
REQ-021 Latency: result sampled at edge N appears on outputs after edge N (1 cycle); first decoded result follows BROADCAST_CNT non-newblock valid cycles after the newblock cycle.
REQ-022 success_o SHALL never be 1 while valid_o is 0.
REQ-023 rawinput_i.success and nonce_prefix SHALL be ignored whenever no result is decoded (REQ-015, REQ-016, REQ-020).
REQ-024 Gaps in valid_i SHALL not reset FILL or ITER; counting resumes on the next valid cycle.

Reset
REQ-025 rst=1 at a rising edge: valid_o=0, success_o=0, nonce_o=0, ITER=0, FILL=0; rst dominates all other inputs.
REQ-026 After reset, no result is decoded until a valid newblock cycle followed by BROADCAST_CNT valid cycles (FILL starts at 0).
REQ-027 Reset mid-enumeration SHALL discard all progress; outputs 0 the cycle after.

Verification (BROADCAST_CNT=5, NUM_CORES=4, PARTITIONBITS=2)
REQ-028 Reset 1 cycle, valid_i=0 -> valid_o=0, success_o=0, nonce_o=0 indefinitely.
REQ-029 valid_i=1 with newblock_i pulse for 1 cycle, then valid_i=1 for 15 cycles, success=0, nonce_prefix=1 -> valid_o=0 for the 5 fill cycles, then valid_o=1 for 10 cycles, success_o=0, nonce_o=0x40000000..0x40000009 consecutively.
REQ-030 As REQ-029 with success=1 on the 3rd decoded cycle only -> success_o=1 exactly one cycle with nonce_o=0x40000002.
REQ-031 valid_i dropped for 3 cycles mid-stream -> valid_o=0 during the gap, nonce_o continues from the next index with no skip.
REQ-032 Second newblock pulse mid-stream -> valid_o=0 for 1+5 cycles, then nonce_o restarts at {prefix,0}.
REQ-033 rst asserted mid-stream -> outputs 0 next cycle; no valid_o until newblock plus 5 fill cycles.
